// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared handshake state codes and rest levels
package hs_pkg;

  // Input side: consumer of the dav_/rfd handshake
  typedef enum logic {
    I_WAIT = 1'b0,
    I_ACK  = 1'b1
  } in_state_t;

  // Output side: responder of the soc/eoc handshake
  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_BUSY = 2'd1,
    O_DONE = 2'd2
  } out_state_t;

  // Levels each handshake line sits at when nothing is happening
  localparam logic DAV_IDLE = 1'b1;
  localparam logic RFD_IDLE = 1'b1;
  localparam logic EOC_IDLE = 1'b1;

endpackage

// File: rtl/dav_soc_bridge_if.sv
// rtl/dav_soc_bridge_if.sv - producer/initiator side signals of the bridge
interface dav_soc_bridge_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  logic [W-1:0]            din;
  logic                    dav_;
  logic                    rfd;
  logic                    soc;
  logic                    eoc;
  logic [W-1:0]            dout;
  logic [$clog2(DEPTH):0]  count;

  // Environment side: produces words and requests conversions
  modport master (
    output din, dav_, soc,
    input  rfd, eoc, dout, count
  );

  // Bridge side
  modport slave (
    input  din, dav_, soc,
    output rfd, eoc, dout, count
  );
endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - word storage, wrapping pointers and occupancy count
module fifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic                   full,
  output logic                   empty,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Write the pushed word; stale contents are unreachable after reset, so no reset here
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; count nets out a simultaneous push and pop
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head is read from the pre-edge pointer, so a word written this edge is not visible until next
  assign head  = mem[rp];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
endmodule

// File: rtl/dav_soc_bridge.sv
// rtl/dav_soc_bridge.sv - dav_/rfd to soc/eoc elastic bridge (two FSMs around a FIFO)
module dav_soc_bridge
  import hs_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_,
  dav_soc_bridge_if.slave bus
);
  in_state_t  in_state;
  out_state_t out_state;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [W-1:0] head;

  // A push needs a fresh dav_ and room; a full FIFO leaves din unsampled
  assign push = (in_state == I_WAIT) && (bus.dav_ != DAV_IDLE) && !full;
  // A pop needs soc released and a stored word from a previous edge
  assign pop  = (out_state == O_BUSY) && !bus.soc && !empty;

  fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .reset_(reset_),
    .push  (push),
    .pop   (pop),
    .wdata (bus.din),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (bus.count)
  );

  // Input FSM: acknowledge a sampled word by dropping rfd until dav_ returns high
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      in_state <= I_WAIT;
      bus.rfd  <= RFD_IDLE;
    end else begin
      case (in_state)
        I_WAIT: if (push) begin
          bus.rfd  <= ~RFD_IDLE;
          in_state <= I_ACK;
        end
        I_ACK: if (bus.dav_ == DAV_IDLE) begin
          bus.rfd  <= RFD_IDLE;
          in_state <= I_WAIT;
        end
      endcase
    end
  end

  // Output FSM: hold eoc low from soc until a word has been loaded into dout for a full cycle
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      out_state <= O_IDLE;
      bus.eoc   <= EOC_IDLE;
      bus.dout  <= '0;
    end else begin
      case (out_state)
        O_IDLE: if (bus.soc) begin
          bus.eoc   <= ~EOC_IDLE;
          out_state <= O_BUSY;
        end
        O_BUSY: if (pop) begin
          bus.dout  <= head;
          out_state <= O_DONE;
        end
        O_DONE: begin
          bus.eoc   <= EOC_IDLE;
          out_state <= O_IDLE;
        end
        default: begin
          bus.eoc   <= EOC_IDLE;
          out_state <= O_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dav_soc_bridge.sv
// tb/tb_dav_soc_bridge.sv - self-checking bench for dav_soc_bridge
module tb_dav_soc_bridge;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset_;
  int   n_cmp = 0;
  int   n_bad = 0;

  dav_soc_bridge_if #(.W(W), .DEPTH(DEPTH)) bus ();

  dav_soc_bridge #(.W(W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of stored words plus the two handshake phases
  logic [7:0] m_q[$];
  bit         m_in_wait;
  int         m_ph;       // 0 idle (eoc high), 1 waiting for a word, 2 word delivered
  logic [7:0] m_dout;
  bit         m_push_evt;
  bit         m_pop_evt;

  always @(posedge clock or negedge reset_) begin : model
    int n;
    if (!reset_) begin
      m_q.delete();
      m_in_wait  = 1'b1;
      m_ph       = 0;
      m_dout     = '0;
      m_push_evt = 1'b0;
      m_pop_evt  = 1'b0;
    end else begin
      n          = m_q.size();
      m_push_evt = m_in_wait && (bus.dav_ == 1'b0) && (n < DEPTH);
      m_pop_evt  = (m_ph == 1) && (bus.soc == 1'b0) && (n > 0);
      if (m_pop_evt)  m_dout = m_q.pop_front();
      if (m_push_evt) m_q.push_back(bus.din);
      if (m_in_wait) begin
        if (m_push_evt) m_in_wait = 1'b0;
      end else if (bus.dav_ == 1'b1) begin
        m_in_wait = 1'b1;
      end
      if (m_ph == 0)      begin if (bus.soc == 1'b1) m_ph = 1; end
      else if (m_ph == 1) begin if (m_pop_evt) m_ph = 2; end
      else                m_ph = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_rfd",   32'(bus.rfd),   32'(m_in_wait));
    chk("model_eoc",   32'(bus.eoc),   32'(m_ph == 0));
    chk("model_count", 32'(bus.count), 32'(m_q.size()));
    chk("model_dout",  32'(bus.dout),  32'(m_dout));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic push_word(input logic [7:0] w);
    bus.dav_ = 1'b0;
    bus.din  = w;
    tick();
    bus.dav_ = 1'b1;
    tick();
  endtask

  task automatic serve_word(input logic [7:0] exp);
    bus.soc = 1'b1;
    tick();
    bus.soc = 1'b0;
    tick();
    chk("serve_dout", 32'(bus.dout), 32'(exp));
    chk("serve_eoc_low", 32'(bus.eoc), 32'd0);
    tick();
    chk("serve_eoc_high", 32'(bus.eoc), 32'd1);
  endtask

  typedef struct {
    logic       dav_n;
    logic [7:0] din;
    logic       soc;
    logic       e_rfd;
    logic       e_eoc;
    logic [2:0] e_count;
    logic [7:0] e_dout;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] served[$];
  int         idx;
  bit         prod_rel;
  bit         same_edge;
  int         cyc;

  initial begin
    // dav_ din soc | rfd eoc count dout  (single transfer of 0x5A)
    vecs[0] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00};
    vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h5A};
    vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h5A};

    reset_   = 1'b0;
    bus.dav_ = 1'b1;
    bus.din  = '0;
    bus.soc  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rfd",   32'(bus.rfd),   32'd1);
    chk("reset_eoc",   32'(bus.eoc),   32'd1);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_dout",  32'(bus.dout),  32'd0);
    reset_ = 1'b1;

    // Single transfer from the table
    for (int i = 0; i < 4; i++) begin
      bus.dav_ = vecs[i].dav_n;
      bus.din  = vecs[i].din;
      bus.soc  = vecs[i].soc;
      tick();
      chk($sformatf("vec%0d_rfd", i),   32'(bus.rfd),   32'(vecs[i].e_rfd));
      chk($sformatf("vec%0d_eoc", i),   32'(bus.eoc),   32'(vecs[i].e_eoc));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_dout", i),  32'(bus.dout),  32'(vecs[i].e_dout));
    end

    // Full FIFO: fifth word must wait for a serve
    for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
    chk("full_count", 32'(bus.count), 32'd4);
    bus.dav_ = 1'b0;
    bus.din  = 8'h14;
    repeat (3) begin
      tick();
      chk("full_rfd_held", 32'(bus.rfd), 32'd1);
    end
    bus.soc = 1'b1;
    tick();
    chk("full_rfd_busy", 32'(bus.rfd), 32'd1);
    bus.soc = 1'b0;
    tick();
    chk("full_first_dout", 32'(bus.dout), 32'h10);
    chk("full_rfd_at_pop", 32'(bus.rfd), 32'd1);
    chk("full_count_pop", 32'(bus.count), 32'd3);
    tick();
    chk("full_accept_rfd", 32'(bus.rfd), 32'd0);
    chk("full_accept_count", 32'(bus.count), 32'd4);
    bus.dav_ = 1'b1;
    for (int i = 1; i < 5; i++) serve_word(8'h10 + 8'(i));
    chk("full_drained", 32'(bus.count), 32'd0);

    // Empty FIFO: eoc held low until a word arrives
    bus.soc = 1'b1;
    tick();
    bus.soc = 1'b0;
    repeat (5) begin
      tick();
      chk("empty_eoc_held", 32'(bus.eoc), 32'd0);
    end
    bus.dav_ = 1'b0;
    bus.din  = 8'h77;
    tick();
    chk("empty_push_count", 32'(bus.count), 32'd1);
    chk("empty_k_eoc", 32'(bus.eoc), 32'd0);
    bus.dav_ = 1'b1;
    tick();
    chk("empty_k1_dout", 32'(bus.dout), 32'h77);
    chk("empty_k1_eoc", 32'(bus.eoc), 32'd0);
    tick();
    chk("empty_k2_eoc", 32'(bus.eoc), 32'd1);

    // Interleaved pushes and serves with wrap-around
    idx       = 0;
    prod_rel  = 1'b0;
    same_edge = 1'b0;
    served.delete();
    cyc       = 0;
    while (served.size() < 10 && cyc < 300) begin
      if (prod_rel) begin
        bus.dav_ = 1'b1;
        prod_rel = 1'b0;
      end else if (idx < 10) begin
        bus.dav_ = 1'b0;
        bus.din  = 8'(idx);
      end else begin
        bus.dav_ = 1'b1;
      end
      bus.soc = (m_ph == 0) ? 1'b1 : 1'b0;
      tick();
      if (m_push_evt) begin
        idx++;
        prod_rel = 1'b1;
      end
      if (m_pop_evt) served.push_back(bus.dout);
      if (m_push_evt && m_pop_evt) begin
        same_edge = 1'b1;
        chk("same_edge_count", 32'(bus.count), 32'(m_q.size()));
      end
      cyc++;
    end
    chk("interleave_done", 32'(served.size()), 32'd10);
    chk("interleave_same_edge", 32'(same_edge), 32'd1);
    for (int i = 0; i < served.size(); i++)
      chk($sformatf("interleave_order%0d", i), 32'(served[i]), 32'(i));
    bus.soc  = 1'b0;
    bus.dav_ = 1'b1;
    repeat (3) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.dav_ = 1'($urandom_range(0, 1));
      bus.din  = 8'($urandom);
      bus.soc  = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset in the middle of both handshakes
    bus.soc  = 1'b0;
    bus.dav_ = 1'b1;
    repeat (4) tick();
    bus.dav_ = 1'b0;
    bus.din  = 8'h3C;
    tick();
    bus.soc = 1'b1;
    tick();
    chk("mid_rfd_low", 32'(bus.rfd), 32'd0);
    chk("mid_eoc_low", 32'(bus.eoc), 32'd0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_rfd",   32'(bus.rfd),   32'd1);
    chk("async_eoc",   32'(bus.eoc),   32'd1);
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_dout",  32'(bus.dout),  32'd0);
    bus.dav_ = 1'b1;
    bus.soc  = 1'b0;
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    push_word(8'hA5);
    chk("after_reset_count", 32'(bus.count), 32'd1);
    serve_word(8'hA5);
    chk("after_reset_empty", 32'(bus.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dav_soc_bridge.md
# dav_soc_bridge

Elastic bridge between a dav_/rfd producer and a soc/eoc initiator. The input side acts as the consumer of a dav_/rfd handshake and stores each accepted word in a small FIFO. The output side acts as the responder ("converter" end) of a soc/eoc handshake and serves one stored word per conversion request. It can sit in front of any block that reads its operands through soc/eoc, for example the three-input minimum unit, and feed it from byte streams.

## Interface
- W, 8, data width in bits
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2
- clock  in  1  single system clock, posedge active
- reset_  in  1  asynchronous, active-low reset
- din  in  W  input word; valid while dav_ = 0
- dav_  in  1  producer data-valid, active low
- rfd  out  1  ready-for-data / acknowledge to producer
- soc  in  1  start-of-conversion from initiator
- eoc  out  1  end-of-conversion to initiator
- dout  out  W  served word; stable whenever eoc = 1
- count  out  $clog2(DEPTH)+1  number of words currently stored

## Operation
- Reset (asynchronous, reset_ = 0): rfd = 1, eoc = 1, dout = 0, count = 0, both pointers = 0, input FSM = I_WAIT, output FSM = O_IDLE.
- Input FSM (dav_/rfd consumer):
  - I_WAIT (rfd = 1): if dav_ = 0 and count < DEPTH, then mem[wp] <= din, wp++, rfd <= 0, go to I_ACK. If the FIFO is full, stay in I_WAIT with rfd = 1 and leave din unsampled.
  - I_ACK (rfd = 0): if dav_ = 1, then rfd <= 1 and go to I_WAIT.
- Output FSM (soc/eoc responder):
  - O_IDLE (eoc = 1): if soc = 1, then eoc <= 0 and go to O_BUSY.
  - O_BUSY (eoc = 0): if soc = 0 and count > 0, then dout <= mem[rp], rp++, go to O_DONE. If the FIFO is empty, hold eoc = 0 until a word arrives.
  - O_DONE: eoc <= 1, go to O_IDLE. dout changes only on the O_BUSY to O_DONE edge, so it is stable for one full cycle before eoc rises.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- count is updated as follows at each edge:
  - +1 on a push only.
  - −1 on a pop only.
  - Unchanged when a push and a pop happen on the same edge.
- There is no bypass. A word written on edge k can be popped on edge k+1 at the earliest.
- Words are delivered strictly in FIFO order and none are lost or duplicated.

## Timing
- Push: dav_ sampled low at edge k. rfd falls after edge k and count increments at edge k.
- rfd returns to 1 on the first edge at which dav_ = 1 is sampled.
- Serve, with FIFO non-empty:
  - soc sampled 1 at edge j: eoc falls.
  - soc sampled 0 at edge m > j: dout is loaded.
  - Edge m+1: eoc rises.
- Serve, with FIFO empty: push at edge k, dout loaded at edge k+1, eoc = 1 after edge k+2, provided soc is already low.
- Full FIFO: a pending dav_ = 0 is accepted on the first edge after a pop makes count < DEPTH.
- The two FSMs are fully independent. A simultaneous push and pop at DEPTH or at 0 is legal only when the pre-edge count permits each operation separately.
- Reset asserted mid-handshake aborts both FSMs immediately and discards stored words. After reset_ deasserts, the first edge evaluates from the reset state.
- Inputs are synchronous to clock; no synchronizers are included.

## Structure
- Shared package hs_pkg contains:
  - input FSM state codes I_WAIT, I_ACK;
  - output FSM state codes O_IDLE, O_BUSY, O_DONE;
  - the rest levels of the handshakes (DAV_IDLE = 1, RFD_IDLE = 1, EOC_IDLE = 1).
- Sub-module fifo_mem holds storage, pointers and count. Its push/pop inputs are a single-cycle strobe each, and it provides full/empty/head outputs.
- The top level contains only the two FSMs and the dout register.

## Test plan
- Reset: hold reset_ = 0 mid-simulation. Expect rfd = 1, eoc = 1, dout = 0x00, count = 0 asynchronously, without waiting for a clock edge.
- Single transfer:
  - Push 0x5A via dav_/rfd, then run a full soc cycle.
  - Expect count 0→1→0.
  - Expect dout = 0x5A one cycle before eoc rises.
- Full FIFO (DEPTH = 4):
  - Push 0x10, 0x11, 0x12, 0x13. Expect count = 4.
  - Drive a fifth word 0x14 with dav_ = 0. Expect rfd to stay 1 until one serve completes.
  - Then expect 0x14 accepted and serves to return 0x10..0x14 in order.
- Empty FIFO:
  - Raise soc and then drop it while the FIFO is empty. Expect eoc held at 0 indefinitely.
  - Push 0x77 at edge k. Expect dout = 0x77 at edge k+1 and eoc = 1 at edge k+2.
- Concurrency and wrap-around:
  - Interleave 10 pushes (0x00..0x09) with serves so that at least one push and one pop share an edge.
  - Expect count unchanged on that edge, pointers to wrap twice, and output order 0x00..0x09.
- Reset mid-operation:
  - Assert reset_ while in I_ACK with rfd = 0 and O_BUSY with eoc = 0.
  - Expect rfd = 1, eoc = 1, count = 0 immediately.
  - A subsequent push/serve of 0xA5 must work normally.
